// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I integer decode-and-issue stage in front of the ALU.
// Decodes one instruction per cycle into ALU selector + operands and
// presents them through a two-entry skid buffer (output reg + skid reg).
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN adds out_illegal and squashes
// unsupported or malformed encodings into a harmless no-write add.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_dataA,
  output logic [31:0] out_dataB,
  output logic [3:0]  out_selector,
  output logic [4:0]  out_rd,
  output logic        out_wen
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        out_illegal
`endif
);

  typedef enum logic [3:0] {
    SEL_ADD  = 4'b0000,
    SEL_SLL  = 4'b0001,
    SEL_SLT  = 4'b0010,
    SEL_SLTU = 4'b0011,
    SEL_XOR  = 4'b0100,
    SEL_SRL  = 4'b0101,
    SEL_OR   = 4'b0110,
    SEL_AND  = 4'b0111,
    SEL_SUB  = 4'b1000,
    SEL_SRA  = 4'b1001
  } sel_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opc_e;

  typedef struct packed {
    logic [31:0] dataA;
    logic [31:0] dataB;
    sel_e        selector;
    logic [4:0]  rd;
    logic        wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        illegal;
`endif
  } payload_t;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_supported;
  payload_t   w_dec;
  payload_t   w_next;
  logic       w_accept;

  payload_t   r_or;
  payload_t   r_sr;
  logic       r_orValid;
  logic       r_srValid;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // funct3 -> selector; alt picks sub/sra where the encoding allows it
  function automatic sel_e aluSel(input logic [2:0] f3, input logic alt);
    sel_e s;
    case (f3)
      3'b000:  s = alt ? SEL_SUB : SEL_ADD;
      3'b001:  s = SEL_SLL;
      3'b010:  s = SEL_SLT;
      3'b011:  s = SEL_SLTU;
      3'b100:  s = SEL_XOR;
      3'b101:  s = alt ? SEL_SRA : SEL_SRL;
      3'b110:  s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

  // Decode opcode into operands and selector; unsupported opcodes stay zero
  always_comb begin
    w_dec       = '0;
    w_supported = 1'b0;
    w_dec.rd    = in_instr[11:7];
    case (w_opcode)
      OPC_OP: begin
        w_supported    = 1'b1;
        w_dec.dataA    = in_rs1_data;
        w_dec.dataB    = in_rs2_data;
        w_dec.selector = aluSel(w_funct3, in_instr[30]);
      end
      OPC_OPIMM: begin
        w_supported    = 1'b1;
        w_dec.dataA    = in_rs1_data;
        w_dec.selector = aluSel(w_funct3, (w_funct3 == 3'b101) && in_instr[30]);
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
          w_dec.dataB = {27'b0, in_instr[24:20]};
        else
          w_dec.dataB = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LUI: begin
        w_supported = 1'b1;
        w_dec.dataB = {in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        w_supported = 1'b1;
        w_dec.dataA = in_pc;
        w_dec.dataB = {in_instr[31:12], 12'b0};
      end
      default: w_supported = 1'b0;
    endcase
    w_dec.wen = w_supported && (in_instr[11:7] != 5'd0);
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic w_illegal;

  // Flag unsupported opcodes and funct7 values outside the defined set
  always_comb begin
    w_illegal = !w_supported;
    if (w_opcode == OPC_OP)
      w_illegal = (w_funct7 != 7'b0000000) &&
                  !((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
    else if (w_opcode == OPC_OPIMM && w_funct3 == 3'b001)
      w_illegal = (w_funct7 != 7'b0000000);
    else if (w_opcode == OPC_OPIMM && w_funct3 == 3'b101)
      w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
  end

  // Illegal items travel as a zero-operand add that never writes back
  always_comb begin
    w_next         = w_dec;
    w_next.illegal = w_illegal;
    if (w_illegal) begin
      w_next.dataA    = '0;
      w_next.dataB    = '0;
      w_next.selector = SEL_ADD;
      w_next.wen      = 1'b0;
    end
  end

  assign out_illegal = r_or.illegal;
`else
  assign w_next = w_dec;
`endif

  assign in_ready = rst_n && !r_srValid;
  assign w_accept = in_valid && in_ready;

  // Skid buffer: OR feeds the ALU, SR catches the one item that arrives
  // while OR is stalled; SR always refills OR before new input is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_or      <= '0;
      r_sr      <= '0;
      r_orValid <= 1'b0;
      r_srValid <= 1'b0;
    end else if (r_srValid) begin
      if (out_ready) begin
        r_or      <= r_sr;
        r_srValid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_orValid || out_ready) begin
        r_or      <= w_next;
        r_orValid <= 1'b1;
      end else begin
        r_sr      <= w_next;
        r_srValid <= 1'b1;
      end
    end else if (out_ready) begin
      r_orValid <= 1'b0;
    end
  end

  assign out_valid    = r_orValid;
  assign out_dataA    = r_or.dataA;
  assign out_dataB    = r_or.dataB;
  assign out_selector = r_or.selector;
  assign out_rd       = r_or.rd;
  assign out_wen      = r_or.wen;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage
// against a mnemonic-level decode model and a FIFO occupancy model.
// Honours ALU_ISSUE_ILLEGAL_EN when the design is built with it.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_dataA;
  logic [31:0] out_dataB;
  logic [3:0]  out_selector;
  logic [4:0]  out_rd;
  logic        out_wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        out_illegal;
`endif

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dataA    (out_dataA),
    .out_dataB    (out_dataB),
    .out_selector (out_selector),
    .out_rd       (out_rd),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .out_illegal  (out_illegal),
`endif
    .out_wen      (out_wen)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } issue_t;

  issue_t     expQ[$];
  logic [3:0] selTable[string];
  int         checkCount = 0;
  int         errCount = 0;
  bit         zeroPayload = 1'b0;

  // Free-running clock, rising edge at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, asserted, reported on mismatch
  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected issue payload from the instruction's mnemonic meaning
  function automatic issue_t expectIssue(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2);
    issue_t e;
    string  op;
    bit     ok;
    bit     bad;
    logic [6:0] f7;
    f7  = ins[31:25];
    ok  = 1'b1;
    bad = 1'b0;
    e.a = 32'h0;
    e.b = 32'h0;
    case (ins[14:12])
      3'd0: op = "add";
      3'd1: op = "sll";
      3'd2: op = "slt";
      3'd3: op = "sltu";
      3'd4: op = "xor";
      3'd5: op = "srl";
      3'd6: op = "or";
      default: op = "and";
    endcase
    if (ins[6:0] == 7'h33) begin
      if (op == "add" && ins[30]) op = "sub";
      if (op == "srl" && ins[30]) op = "sra";
      e.a = r1;
      e.b = r2;
      bad = !(f7 == 7'h00 || (f7 == 7'h20 && (op == "sub" || op == "sra")));
    end else if (ins[6:0] == 7'h13) begin
      e.a = r1;
      if (op == "sll" || op == "srl") begin
        e.b = 32'(ins[24:20]);
        if (op == "srl" && ins[30]) op = "sra";
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && op == "sra"));
      end else begin
        e.b = 32'($signed(ins[31:20]));
      end
    end else if (ins[6:0] == 7'h37) begin
      op  = "add";
      e.b = {ins[31:12], 12'h000};
    end else if (ins[6:0] == 7'h17) begin
      op  = "add";
      e.a = pc;
      e.b = {ins[31:12], 12'h000};
    end else begin
      op = "add";
      ok = 1'b0;
    end
    e.sel = selTable[op];
    e.rd  = ins[11:7];
    e.wen = ok && (ins[11:7] != 5'd0);
    e.ill = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    e.ill = !ok || bad;
    if (e.ill) begin
      e.a   = 32'h0;
      e.b   = 32'h0;
      e.sel = 4'b0000;
      e.wen = 1'b0;
    end
`else
    if (bad) e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Compare all visible outputs with the occupancy model and queue head
  task automatic checkOutput();
    issue_t e;
    checkValue("in_ready", 32'(in_ready), 32'(rst_n && expQ.size() < 2));
    checkValue("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
    if (expQ.size() > 0) begin
      e = expQ[0];
      checkValue("out_dataA", out_dataA, e.a);
      checkValue("out_dataB", out_dataB, e.b);
      checkValue("out_selector", 32'(out_selector), 32'(e.sel));
      checkValue("out_rd", 32'(out_rd), 32'(e.rd));
      checkValue("out_wen", 32'(out_wen), 32'(e.wen));
`ifdef ALU_ISSUE_ILLEGAL_EN
      checkValue("out_illegal", 32'(out_illegal), 32'(e.ill));
`endif
    end else if (zeroPayload) begin
      checkValue("rst_dataA", out_dataA, 32'h0);
      checkValue("rst_dataB", out_dataB, 32'h0);
      checkValue("rst_selector", 32'(out_selector), 32'h0);
      checkValue("rst_rd", 32'(out_rd), 32'h0);
      checkValue("rst_wen", 32'(out_wen), 32'h0);
`ifdef ALU_ISSUE_ILLEGAL_EN
      checkValue("rst_illegal", 32'(out_illegal), 32'h0);
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic ordy, input logic rst);
    bit accept;
    bit drain;
    in_valid    = v;
    in_instr    = ins;
    in_pc       = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
    out_ready   = ordy;
    rst_n       = rst;
    accept = v && rst && (expQ.size() < 2);
    drain  = rst && (expQ.size() > 0) && ordy;
    @(negedge clk);
    if (!rst) begin
      expQ.delete();
      zeroPayload = 1'b1;
    end else begin
      if (drain) void'(expQ.pop_front());
      if (accept) begin
        expQ.push_back(expectIssue(ins, pc, r1, r2));
        zeroPayload = 1'b0;
      end
    end
    checkOutput();
  endtask

  // Random instruction biased towards the supported opcodes
  function automatic logic [31:0] randInstr();
    logic [31:0] ins;
    int          kind;
    int          f7pick;
    ins    = $urandom;
    kind   = $urandom_range(0, 9);
    f7pick = $urandom_range(0, 2);
    if (kind <= 3) begin
      ins[6:0] = 7'h33;
      if (f7pick == 0) ins[31:25] = 7'h00;
      else if (f7pick == 1) ins[31:25] = 7'h20;
    end else if (kind <= 6) begin
      ins[6:0] = 7'h13;
      if (f7pick == 0) ins[31:25] = 7'h00;
      else if (f7pick == 1) ins[31:25] = 7'h20;
    end else if (kind == 7) begin
      ins[6:0] = 7'h37;
    end else if (kind == 8) begin
      ins[6:0] = 7'h17;
    end
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  initial begin
    int idx;
    int nextExp;
    int budget;
    selTable["add"]  = 4'b0000;
    selTable["sll"]  = 4'b0001;
    selTable["slt"]  = 4'b0010;
    selTable["sltu"] = 4'b0011;
    selTable["xor"]  = 4'b0100;
    selTable["srl"]  = 4'b0101;
    selTable["or"]   = 4'b0110;
    selTable["and"]  = 4'b0111;
    selTable["sub"]  = 4'b1000;
    selTable["sra"]  = 4'b1001;

    // Reset, then release
    applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkValue("reset_out_valid", 32'(out_valid), 32'h0);
    checkValue("reset_in_ready_low", 32'(in_ready), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    checkValue("reset_in_ready_high", 32'(in_ready), 32'h1);

    // ADD x3,x1,x2
    applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1);
    checkValue("add_valid", 32'(out_valid), 32'h1);
    checkValue("add_sel", 32'(out_selector), 32'h0);
    checkValue("add_A", out_dataA, 32'd5);
    checkValue("add_B", out_dataB, 32'd7);
    checkValue("add_rd", 32'(out_rd), 32'd3);
    checkValue("add_wen", 32'(out_wen), 32'h1);

    // SRAI x5,x6,4
    applyStimulus(1'b1, 32'h40435293, 32'h0, 32'hF0000000, 32'h0, 1'b1, 1'b1);
    checkValue("srai_sel", 32'(out_selector), 32'h9);
    checkValue("srai_A", out_dataA, 32'hF0000000);
    checkValue("srai_B", out_dataB, 32'h4);
    checkValue("srai_wen", 32'(out_wen), 32'h1);

    // AUIPC x1,0x12345 at pc 0x100
    applyStimulus(1'b1, 32'h12345097, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1);
    checkValue("auipc_A", out_dataA, 32'h100);
    checkValue("auipc_B", out_dataB, 32'h12345000);
    checkValue("auipc_sel", 32'(out_selector), 32'h0);
    checkValue("auipc_rd", 32'(out_rd), 32'd1);

    // LUI x0,0x1 never writes
    applyStimulus(1'b1, 32'h00001037, 32'h0, 32'h55, 32'h66, 1'b1, 1'b1);
    checkValue("lui_x0_wen", 32'(out_wen), 32'h0);
    checkValue("lui_x0_B", out_dataB, 32'h1000);
    checkValue("lui_x0_A", out_dataA, 32'h0);

`ifdef ALU_ISSUE_ILLEGAL_EN
    applyStimulus(1'b1, 32'h0000007F, 32'h0, 32'h1, 32'h2, 1'b1, 1'b1);
    checkValue("ill_opc_flag", 32'(out_illegal), 32'h1);
    checkValue("ill_opc_wen", 32'(out_wen), 32'h0);
    checkValue("ill_opc_sel", 32'(out_selector), 32'h0);
    applyStimulus(1'b1, 32'h022081B3, 32'h0, 32'h1, 32'h2, 1'b1, 1'b1);
    checkValue("ill_f7_flag", 32'(out_illegal), 32'h1);
`endif

    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    checkValue("idle_valid", 32'(out_valid), 32'h0);

    // Back-pressure: ADDI x1,x0,k for k = 1..4, stall after the first
    applyStimulus(1'b1, 32'h00100093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    idx = 2;
    for (int c = 0; c < 3; c++) begin
      if (expQ.size() < 2) begin
        applyStimulus(1'b1, (32'(idx) << 20) | 32'h093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        idx++;
      end else begin
        applyStimulus(1'b1, (32'(idx) << 20) | 32'h093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      end
      checkValue("bp_in_ready_low", 32'(in_ready), 32'h0);
      checkValue("bp_head_stable", out_dataB, 32'd1);
    end
    nextExp = 1;
    budget  = 0;
    while (nextExp < 5 && budget < 20) begin
      if (out_valid === 1'b1) begin
        checkValue("bp_order", out_dataB, 32'(nextExp));
        nextExp++;
      end
      if (idx <= 4 && expQ.size() < 2) begin
        applyStimulus(1'b1, (32'(idx) << 20) | 32'h093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        idx++;
      end else begin
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      end
      budget++;
    end
    checkValue("bp_all_out", 32'(nextExp), 32'd5);

    // Reset with OR and SR both full
    applyStimulus(1'b1, 32'h00900093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h00A00093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkValue("mid_full_in_ready", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, 32'h00B00093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkValue("mid_rst_valid", 32'(out_valid), 32'h0);
    checkValue("mid_rst_B", out_dataB, 32'h0);
    checkValue("mid_rst_rd", 32'(out_rd), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    checkValue("mid_rel_in_ready", 32'(in_ready), 32'h1);
    checkValue("mid_rel_valid", 32'(out_valid), 32'h0);

    // Randomized traffic with random back-pressure and rare resets
    for (int c = 0; c < 600; c++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randInstr(), $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 79) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
